// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline definitions: default sizing, reset address and the
// queue entry layout that travels from fetch to decode.
package pipe_pkg;

    localparam int          XLEN         = 32;
    localparam int          DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // One queued fetch: the instruction and the address of the next sequential fetch.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pcplus4;
    } entry_t;

endpackage : pipe_pkg

// File: rtl/adder.sv
// Plain combinational adder, shared across the pipeline for address arithmetic.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Sum wraps modulo 2^WIDTH.
    assign y = a + b;

endmodule : adder

// File: rtl/fetch_buffer.sv
// Decoupling queue between instruction fetch and decode. Fetches sequentially
// while there is room, hands the oldest entry to decode, and restarts at a new
// address when decode redirects the stream.
module fetch_buffer
    import pipe_pkg::*;
#(
    parameter int              DEPTH    = DEPTH_DEF,
    parameter int              WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [WIDTH-1:0]         pcF,
    input  logic [WIDTH-1:0]         instrF,
    input  logic                     redirect,
    input  logic [WIDTH-1:0]         redirect_pc,
    input  logic                     readyD,
    output logic                     validD,
    output logic [WIDTH-1:0]         instrD,
    output logic [WIDTH-1:0]         pcplus4D,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d, pc_plus4;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, push, pop, push_en, pop_en;
    entry_t           mem_q [DEPTH];
    entry_t           head_entry;

    adder #(.WIDTH(WIDTH)) u_pc_adder (
        .a (pc_q),
        .b (WIDTH'(4)),
        .y (pc_plus4)
    );

    assign full   = (count_q == CW'(DEPTH));
    assign validD = (count_q != '0);
    assign pop    = validD & readyD;
    assign push   = ~full | pop;

    // A redirect cancels both the fetch and the hand-off this cycle.
    assign push_en = push & ~redirect;
    assign pop_en  = pop & ~redirect;

    // Next-state for fetch address, pointers and occupancy; redirect wins.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) begin
                pc_d   = pc_plus4;
                tail_d = tail_q + PW'(1);
            end
            if (pop_en) begin
                head_d = head_q + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: write the fetched instruction at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; stale contents are hidden because outputs are masked by validD.
        if (push_en) begin
            mem_q[tail_q] <= '{instr: instrF, pcplus4: pc_plus4};
        end
    end

    assign head_entry = mem_q[head_q];
    assign pcF        = pc_q;
    assign instrD     = validD ? head_entry.instr   : '0;
    assign pcplus4D   = validD ? head_entry.pcplus4 : '0;
    assign count      = count_q;

endmodule : fetch_buffer

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a DEPTH=4 and a DEPTH=2 instance run side by side
// against a queue-based reference model of the fetch stream.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_a, redirect_b;
    logic [31:0] redirect_pc_a, redirect_pc_b;
    logic        ready_a, ready_b;

    logic [31:0] pcF_a, pcF_b, instrF_a, instrF_b;
    logic        validD_a, validD_b;
    logic [31:0] instrD_a, instrD_b, pcplus4D_a, pcplus4D_b;
    logic [2:0]  count_a;
    logic [1:0]  count_b;

    int total = 0;
    int bad   = 0;

    // Reference model: fetch address and a queue of fetched addresses per instance.
    logic [31:0] mpc [2];
    logic [31:0] mq0 [$];
    logic [31:0] mq1 [$];
    int          mdepth [2] = '{4, 2};

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        return addr * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    assign instrF_a = imem(pcF_a);
    assign instrF_b = imem(pcF_b);

    fetch_buffer #(.DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .pcF(pcF_a), .instrF(instrF_a),
        .redirect(redirect_a), .redirect_pc(redirect_pc_a), .readyD(ready_a),
        .validD(validD_a), .instrD(instrD_a), .pcplus4D(pcplus4D_a), .count(count_a)
    );

    fetch_buffer #(.DEPTH(2)) u_b (
        .clk(clk), .reset(reset), .pcF(pcF_b), .instrF(instrF_b),
        .redirect(redirect_b), .redirect_pc(redirect_pc_b), .readyD(ready_b),
        .validD(validD_b), .instrD(instrD_b), .pcplus4D(pcplus4D_b), .count(count_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model.
    task automatic check_all();
        logic [31:0] h0, h1;
        h0 = (mq0.size() != 0) ? mq0[0] : 32'h0;
        h1 = (mq1.size() != 0) ? mq1[0] : 32'h0;
        chk("a_pcF",      pcF_a,          mpc[0]);
        chk("a_count",    32'(count_a),   32'(mq0.size()));
        chk("a_validD",   32'(validD_a),  32'(mq0.size() != 0));
        chk("a_instrD",   instrD_a,       (mq0.size() != 0) ? imem(h0) : 32'h0);
        chk("a_pcplus4D", pcplus4D_a,     (mq0.size() != 0) ? h0 + 32'd4 : 32'h0);
        chk("b_pcF",      pcF_b,          mpc[1]);
        chk("b_count",    32'(count_b),   32'(mq1.size()));
        chk("b_validD",   32'(validD_b),  32'(mq1.size() != 0));
        chk("b_instrD",   instrD_b,       (mq1.size() != 0) ? imem(h1) : 32'h0);
        chk("b_pcplus4D", pcplus4D_b,     (mq1.size() != 0) ? h1 + 32'd4 : 32'h0);
    endtask

    // Advance the model by one clock edge, given the inputs presented.
    task automatic model_edge();
        bit pop, push;
        if (redirect_a) begin
            mq0.delete();
            mpc[0] = redirect_pc_a;
        end else begin
            pop  = (mq0.size() != 0) && ready_a;
            push = (mq0.size() < mdepth[0]) || pop;
            if (pop)  void'(mq0.pop_front());
            if (push) begin mq0.push_back(mpc[0]); mpc[0] = mpc[0] + 32'd4; end
        end
        pop  = (mq1.size() != 0) && ready_b;
        push = (mq1.size() < mdepth[1]) || pop;
        if (pop)  void'(mq1.pop_front());
        if (push) begin mq1.push_back(mpc[1]); mpc[1] = mpc[1] + 32'd4; end
    endtask

    // Entered and left at a falling edge: present inputs, check, clock once.
    task automatic step(input bit ra, input bit rb, input bit rd, input logic [31:0] rpc);
        ready_a       = ra;
        ready_b       = rb;
        redirect_a    = rd;
        redirect_pc_a = rpc;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        mpc[0] = 32'h0;
        mpc[1] = 32'h0;
    endtask

    // Pulse reset low for one cycle from a falling edge, checking outputs while held.
    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_pcF",      pcF_a,        32'h0);
        chk("rst_count",    32'(count_a), 32'h0);
        chk("rst_validD",   32'(validD_a), 32'h0);
        chk("rst_instrD",   instrD_a,     32'h0);
        chk("rst_pcplus4D", pcplus4D_a,   32'h0);
        chk("rst_b_count",  32'(count_b), 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        ready_a       = 1'b0;
        ready_b       = 1'b0;
        redirect_a    = 1'b0;
        redirect_b    = 1'b0;
        redirect_pc_a = 32'h0;
        redirect_pc_b = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_pulse();

        // Sequential fetch with decode always ready.
        for (int k = 0; k < 4; k++) begin
            chk("seq_pcF", pcF_a, 32'(4 * k));
            step(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("seq_valid", 32'(validD_a), 32'h1);

        // Decode stalled: queue fills and fetch freezes.
        reset_pulse();
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("stall_count", 32'(count_a), 32'd4);
        chk("stall_pcF",   pcF_a,        32'd16);
        // Release: drain in order while full, fetch continues every cycle.
        for (int k = 1; k <= 4; k++) begin
            chk("drain_pcplus4D", pcplus4D_a, 32'(4 * k));
            chk("drain_instrD",   instrD_a,   imem(32'(4 * (k - 1))));
            step(1'b1, 1'b1, 1'b0, 32'h0);
            chk("full_count", 32'(count_a), 32'd4);
            chk("full_pcF",   pcF_a,        32'(16 + 4 * k));
        end

        // Redirect with three entries queued.
        reset_pulse();
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_redir_count", 32'(count_a), 32'd3);
        step(1'b1, 1'b1, 1'b1, 32'h40);
        chk("redir_count",  32'(count_a),  32'd0);
        chk("redir_valid",  32'(validD_a), 32'd0);
        chk("redir_pcF",    pcF_a,         32'h40);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_valid2", 32'(validD_a), 32'd1);
        chk("redir_pcp4",   pcplus4D_a,    32'h44);

        // Address wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_pcF0", pcF_a, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pcF1", pcF_a, 32'h0);
        chk("wrap_pcp4", pcplus4D_a, 32'h0);
        chk("wrap_valid", 32'(validD_a), 32'd1);

        // Reset in the middle of operation with two entries queued.
        reset_pulse();
        repeat (2) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("mid_count", 32'(count_a), 32'd2);
        reset_pulse();
        chk("post_rst_pcF",   pcF_a,        32'h0);
        chk("post_rst_count", 32'(count_a), 32'd0);

        // DEPTH=2 pointer wrap: ten push/pop pairs after filling.
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            chk("d2_pcplus4D", pcplus4D_b, 32'(4 * k + 4));
            step(1'b1, 1'b1, 1'b0, 32'h0);
            assert (count_b <= 2'd2) else begin
                bad++;
                $error("FAIL d2_count_bound observed=%0d expected<=2", count_b);
            end
            total++;
        end

        // Randomized traffic with occasional redirects.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] tgt;
            bit          rd;
            rd  = ($urandom_range(15) == 0);
            tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(9) < 7, $urandom_range(1) == 1, rd, tgt);
        end
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_buffer

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-002 Parameter WIDTH, default 32: instruction and address width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pcF  out  WIDTH  current fetch address driven to instruction memory.
REQ-007 instrF  in  WIDTH  instruction returned combinationally for pcF in the same cycle.
REQ-008 redirect  in  1  branch/jump taken in decode; flushes the queue.
REQ-009 redirect_pc  in  WIDTH  target address, valid when redirect=1.
REQ-010 readyD  in  1  decode accepts the head entry this cycle (equals ~stallD).
REQ-011 validD  out  1  head entry present.
REQ-012 instrD  out  WIDTH  head instruction; 0 when validD=0.
REQ-013 pcplus4D  out  WIDTH  head fetch address + 4; 0 when validD=0.
REQ-014 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 push = ~full | pop; pop = validD & readyD; full = (count == DEPTH).
REQ-016 When push=1 and redirect=0, {instrF, pcF+4} is written at the tail and pcF advances to pcF+4 on the next edge.
REQ-017 When push=0 and redirect=0, pcF holds and instrF is ignored.
REQ-018 Head outputs are read combinationally from storage; latency is 1 cycle from fetch to validD.
REQ-019 Simultaneous push and pop (including when full) leaves count unchanged and advances both pointers.
REQ-020 When redirect=1, on the next edge:
  - count becomes 0 and both pointers become 0;
  - pcF becomes redirect_pc;
  - no push occurs;
  - pop is ignored.
  Redirect has priority over every other event.
REQ-021 Head and tail pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 Address arithmetic is modulo 2^WIDTH; pcF = 2^WIDTH-4 advances to 0.
REQ-023 No overflow: a push while full without a pop is impossible by construction.
REQ-024 No underflow: pop is gated by validD.
REQ-025 validD = (count != 0).

Reset
REQ-026 While reset=0, asynchronously: pcF=RESET_PC, count=0, head=tail=0, validD=0, instrD=0, pcplus4D=0.
REQ-027 Reset asserted mid-operation discards all queued entries with no partial write.
REQ-028 The first fetch at RESET_PC occurs on the first rising edge after reset deasserts.
REQ-029 Storage array contents are not reset; outputs are masked by validD.

Structure
REQ-030 Shared package pipe_pkg holds the DEPTH default, the RESET_PC default and the entry struct {instr, pcplus4}.
REQ-031 The existing adder module is instantiated once for pcF+4.
REQ-032 Storage, pointers and count are implemented inline; no other sub-module.

Verification
REQ-033 Reset release, readyD=1 held: pcF sequence 0,4,8,12; validD=1 from cycle 2; instrD follows the imem contents in order.
REQ-034 readyD=0 held for 6 cycles with DEPTH=4:
  - count reaches 4;
  - pcF freezes at 16;
  - releasing readyD drains the entries with pcplus4D 4,8,12,16, no instruction lost or duplicated.
REQ-035 Queue full with readyD=1: count stays 4 and pcF advances by 4 every cycle.
REQ-036 redirect=1, redirect_pc=32'h40 with count=3 and readyD=1:
  - next cycle count=0, validD=0, pcF=32'h40;
  - the cycle after, validD=1 with pcplus4D=32'h44.
REQ-037 reset pulled low for 1 cycle while count=2: outputs are zero immediately; after release pcF=RESET_PC and count=0.
REQ-038 Pointer wrap with DEPTH=2 over 10 push/pop pairs: the FIFO order of pcplus4D is preserved and count never exceeds 2.
